uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-write / status / line bundle between a producer and uart_tx_fifo.
// Handshake: there is no back-pressure. A byte on wrData is taken on every
// rising clk edge where wrEn is high and full is low. If full is high, the
// byte is dropped and overflow latches. The producer must watch full/count
// itself. state is a read-only debug view of the serializer FSM.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          wrEn;
  logic [7:0]                    wrData;
  logic                          full;
  logic                          empty;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          overflow;
  logic                          tx;
  logic                          txBusy;
  logic [2:0]                    state;

  modport master (
    output wrEn, wrData,
    input  full, empty, count, overflow, tx, txBusy, state
  );

  modport slave (
    input  wrEn, wrData,
    output full, empty, count, overflow, tx, txBusy, state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO. Frame: 8N1, LSB first. Each line bit
// lasts CLK_FREQ/BAUD clk cycles. tx and txBusy are registered.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, giving an 11-bit frame.
// The state debug encoding is IDLE=0, START=1, DATA=2, STOP=3, PARITY=4.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           uartTxRstN,
  uart_tx_fifo_if.slave  bus
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int DW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3
  } state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q, cnt_next;
  logic          full_q, empty_q, ovf_q;

  state_t        state;
  logic [DW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q, busy_q, line_bit;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic push, pop, baud_end;

  // A full FIFO drops the write even if a pop happens in the same cycle.
  assign push     = bus.wrEn && !full_q;
  assign baud_end = (baud_cnt == DW'(BAUD_DIV - 1));
  // Pop from IDLE right away, or at the last cycle of STOP for gapless frames.
  assign pop      = !empty_q && ((state == S_IDLE) || (state == S_STOP && baud_end));

  // Next occupancy: a simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_next = cnt_q;
    if (push && !pop)      cnt_next = cnt_q + 1'b1;
    else if (pop && !push) cnt_next = cnt_q - 1'b1;
  end

  // Line level for the current state. tx_q registers this value one cycle later.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      S_START:  line_bit = 1'b0;
      S_DATA:   line_bit = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_bit = par_q;
`endif
      default:  line_bit = 1'b1;
    endcase
  end

  // Byte storage. It has no reset, because the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wrData;
  end

  // FIFO pointers, registered flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge uartTxRstN) begin
    if (!uartTxRstN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.wrEn && full_q) ovf_q <= 1'b1;
      cnt_q   <= cnt_next;
      full_q  <= (cnt_next == CW'(FIFO_DEPTH));
      empty_q <= (cnt_next == '0);
    end
  end

  // Serializer FSM with registered tx/txBusy. Reset abandons any partial frame.
  always_ff @(posedge clk or negedge uartTxRstN) begin
    if (!uartTxRstN) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      tx_q <= line_bit;
      if (pop) begin
        shreg  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
        par_q  <= ^mem[rd_ptr];
`endif
        busy_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (pop) state <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              state <= S_START;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;
  assign bus.tx       = tx_q;
  assign bus.txBusy   = busy_q;
  assign bus.state    = state;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_FREQ=16, BAUD=1 (16 clocks per bit)
// and FIFO_DEPTH=4. Inputs change 1 time unit after a rising edge, and outputs
// are sampled at the same point.
module tb_uart_tx_fifo;
  localparam int BIT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk;
  logic uartTxRstN;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo_if #(.FIFO_DEPTH(4)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ   (16),
    .BAUD       (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .uartTxRstN (uartTxRstN),
    .bus        (bus)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write one byte. The edge after this call's posedge is edge N for that byte.
  task automatic write_byte(input logic [7:0] d);
    bus.wrEn   = 1'b1;
    bus.wrData = d;
    step();
    bus.wrEn   = 1'b0;
  endtask

  task automatic pulse_reset();
    uartTxRstN = 1'b0;
    #1;
    uartTxRstN = 1'b1;
    step();
  endtask

  // Check one frame. The call starts at the first sample of the start bit,
  // or at sample 'skip' of it. For each line bit, count the cycles that carry
  // the right level. If 'inject' is set, drive a write into the pop edge at
  // the end of the stop bit.
  task automatic frame_check(input logic [7:0] b, input int skip, input bit inject);
    logic [FB-1:0] bits;
    int ok;
    int k;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    for (int i = 0; i < FB; i++) begin
      ok = 0;
      for (int c = (i == 0) ? skip : 0; c < BIT; c++) begin
        k = i * BIT + c;
        if (bus.tx === bits[i]) ok++;
        if (inject && k == FB * BIT - 2) begin
          bus.wrEn   = 1'b1;
          bus.wrData = 8'h99;
        end
        if (k == FB * BIT - 1) bus.wrEn = 1'b0;
        step();
      end
      check($sformatf("frame_%02h_bit%0d", b, i), ok, (i == 0) ? BIT - skip : BIT);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    bus.tx, 1'b1);
    check({tag, "_busy"},  bus.txBusy, 1'b0);
    check({tag, "_empty"}, bus.empty, 1'b1);
    check({tag, "_count"}, bus.count, 0);
  endtask

  initial begin
    int n;
    uartTxRstN = 1'b1;
    bus.wrEn   = 1'b0;
    bus.wrData = 8'h00;
    #2 uartTxRstN = 1'b0;
    step();
    check("rst_tx",    bus.tx, 1'b1);
    check("rst_busy",  bus.txBusy, 1'b0);
    check("rst_full",  bus.full, 1'b0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_count", bus.count, 0);
    check("rst_ovf",   bus.overflow, 1'b0);
    check("rst_state", bus.state, 0);
    uartTxRstN = 1'b1;
    step();

    // Single write 0x41: start bit fixed at edge N+2.
    write_byte(8'h41);
    check("w1_empty", bus.empty, 1'b0);
    check("w1_count", bus.count, 1);
    check("w1_tx_n",  bus.tx, 1'b1);
    step();
    check("w1_tx_n1",    bus.tx, 1'b1);
    check("w1_state_n1", bus.state, 1);
    check("w1_count_n1", bus.count, 0);
    check("w1_busy_n1",  bus.txBusy, 1'b1);
    step();
    frame_check(8'h41, 0, 0);
    check_idle("w1_end");

    // txBusy length for one frame.
    write_byte(8'h41);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.txBusy) n++;
    end
    check("busy_cycles", n, FB * BIT);

    // Three back-to-back frames.
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h0A);
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h0A);
    check("b2b_count_peak", bus.count, 2);
    frame_check(exp_q.pop_front(), 0, 0);
    check("b2b_count_1", bus.count, 1);
    frame_check(exp_q.pop_front(), 0, 0);
    frame_check(exp_q.pop_front(), 0, 0);
    check_idle("b2b_end");

    // Overflow: six writes. 0x00 pops, 0x01..0x04 fill, 0x05 drops.
    for (int i = 0; i < 6; i++) write_byte(8'(i));
    check("ovf_full",  bus.full, 1'b1);
    check("ovf_count", bus.count, 4);
    check("ovf_flag",  bus.overflow, 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
    frame_check(exp_q.pop_front(), 3, 0);
    check("ovf_count_3", bus.count, 3);
    while (exp_q.size() > 0) frame_check(exp_q.pop_front(), 0, 0);
    check_idle("ovf_end");
    check("ovf_sticky", bus.overflow, 1'b1);

    // Write while full, coincident with the stop-bit-end pop.
    pulse_reset();
    check("rst2_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i));
    check("fp_full",  bus.full, 1'b1);
    check("fp_count", bus.count, 4);
    check("fp_ovf0",  bus.overflow, 1'b0);
    frame_check(8'h10, 2, 1);
    check("fp_count_3", bus.count, 3);
    check("fp_full_0",  bus.full, 1'b0);
    check("fp_ovf1",    bus.overflow, 1'b1);
    for (int i = 1; i < 5; i++) frame_check(8'h10 + 8'(i), 0, 0);
    check_idle("fp_end");

    // Reset in the middle of DATA bit 1 of 0xA5, with two bytes queued.
    pulse_reset();
    write_byte(8'hA5);
    write_byte(8'hB1);
    write_byte(8'hB2);
    repeat (38) step();
    check("mid_tx_low", bus.tx, 1'b0);
    check("mid_count",  bus.count, 2);
    uartTxRstN = 1'b0;
    #1;
    check("mid_rst_tx",    bus.tx, 1'b1);
    check("mid_rst_busy",  bus.txBusy, 1'b0);
    check("mid_rst_empty", bus.empty, 1'b1);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_state", bus.state, 0);
    #1 uartTxRstN = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.tx === 1'b1 && bus.txBusy === 1'b0 && bus.empty === 1'b1) n++;
    end
    check("post_rst_quiet", n, 200);

`ifdef UART_TX_PARITY_EN
    // Parity bit is 1 for 0x07 (three ones) and 0 for 0x03 (two ones).
    write_byte(8'h07);
    step();
    frame_check(8'h07, 0, 0);
    write_byte(8'h03);
    step();
    frame_check(8'h03, 0, 0);
    check_idle("par_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
